alu_reservation_station: RTL and testbench

Parametrised successor to the 4-entry ALU reservation station, with embedded ALU. Holds dispatched ALU, branch and jalr ops until both operands are ready. Issues the oldest ready entry to a registered result port with a valid/ready handshake toward the CDB arbiter. Snoops CDB_NUM broadcast buses, bypasses same-cycle CDB data at dispatch, and fixes signed-compare and shift-amount semantics.

---
 rtl/alu_reservation_station_pkg.sv | 42 ++++
 rtl/alu_reservation_station_rs_alu.sv | 56 +++++
 rtl/alu_reservation_station.sv | 197 +++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared opcode codes and tag helpers for the ALU reservation station.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package alu_reservation_station_pkg;

    // Internal opcode encoding shared by dispatcher and decoder (jalr..andr)
    typedef enum logic [6:0] {
        OP_NONE  = 7'd0,
        OP_JALR  = 7'd1,
        OP_BEQ   = 7'd2,
        OP_BNE   = 7'd3,
        OP_BLT   = 7'd4,
        OP_BGE   = 7'd5,
        OP_BLTU  = 7'd6,
        OP_BGEU  = 7'd7,
        OP_ADDI  = 7'd8,
        OP_SLTI  = 7'd9,
        OP_SLTIU = 7'd10,
        OP_XORI  = 7'd11,
        OP_ORI   = 7'd12,
        OP_ANDI  = 7'd13,
        OP_SLLI  = 7'd14,
        OP_SRLI  = 7'd15,
        OP_SRAI  = 7'd16,
        OP_ADD   = 7'd17,
        OP_SUB   = 7'd18,
        OP_SLL   = 7'd19,
        OP_SLT   = 7'd20,
        OP_SLTU  = 7'd21,
        OP_XORR  = 7'd22,
        OP_SRL   = 7'd23,
        OP_SRA   = 7'd24,
        OP_ORR   = 7'd25,
        OP_ANDR  = 7'd26
    } opcode_e;

    // Producer tag meaning "operand already valid": one past the last RoB index
    function automatic int non_dep(input int rob_width);
        return 1 << rob_width;
    endfunction

endpackage

// File: rtl/alu_reservation_station_rs_alu.sv
// Combinational ALU: arithmetic/logic results, branch targets and jalr targets.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module rs_alu
    import alu_reservation_station_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [31:0] vj_i,
    input  logic [31:0] vk_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] pc_i,
    output logic [31:0] data_o
);
    logic taken;
    logic branch;

    // Decode the opcode; branches select between target and fall-through
    always_comb begin
        data_o = '0;
        taken  = 1'b0;
        branch = 1'b0;
        case (opcode_i)
            OP_JALR:  data_o = (vj_i + imm_i) & ~32'd1;
            OP_BEQ:   begin branch = 1'b1; taken = (vj_i == vk_i); end
            OP_BNE:   begin branch = 1'b1; taken = (vj_i != vk_i); end
            OP_BLT:   begin branch = 1'b1; taken = ($signed(vj_i) < $signed(vk_i)); end
            OP_BGE:   begin branch = 1'b1; taken = ($signed(vj_i) >= $signed(vk_i)); end
            OP_BLTU:  begin branch = 1'b1; taken = (vj_i < vk_i); end
            OP_BGEU:  begin branch = 1'b1; taken = (vj_i >= vk_i); end
            OP_ADDI:  data_o = vj_i + imm_i;
            OP_SLTI:  data_o = {31'd0, ($signed(vj_i) < $signed(imm_i))};
            OP_SLTIU: data_o = {31'd0, (vj_i < imm_i)};
            OP_XORI:  data_o = vj_i ^ imm_i;
            OP_ORI:   data_o = vj_i | imm_i;
            OP_ANDI:  data_o = vj_i & imm_i;
            OP_SLLI:  data_o = vj_i << imm_i[4:0];
            OP_SRLI:  data_o = vj_i >> imm_i[4:0];
            OP_SRAI:  data_o = $unsigned($signed(vj_i) >>> imm_i[4:0]);
            OP_ADD:   data_o = vj_i + vk_i;
            OP_SUB:   data_o = vj_i - vk_i;
            OP_SLL:   data_o = vj_i << vk_i[4:0];
            OP_SLT:   data_o = {31'd0, ($signed(vj_i) < $signed(vk_i))};
            OP_SLTU:  data_o = {31'd0, (vj_i < vk_i)};
            OP_XORR:  data_o = vj_i ^ vk_i;
            OP_SRL:   data_o = vj_i >> vk_i[4:0];
            OP_SRA:   data_o = $unsigned($signed(vj_i) >>> vk_i[4:0]);
            OP_ORR:   data_o = vj_i | vk_i;
            OP_ANDR:  data_o = vj_i & vk_i;
            default:  data_o = '0;
        endcase
        if (branch) begin
            data_o = taken ? (pc_i + imm_i) : (pc_i + 32'd4);
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station holding ALU/branch/jalr ops; issues oldest ready entry through an embedded ALU.
// Latency: an op ready when written is registered on the result port one edge later.
// Backpressure: result held stable while RS_update_en && !RS_update_ready; no issue until accepted.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_WIDTH  = 3,
    parameter int RS_SIZE   = 1 << RS_WIDTH,
    parameter int RoB_WIDTH = 3,
    parameter int NON_DEP   = non_dep(RoB_WIDTH),
    parameter int CDB_NUM   = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         new_entry_en,
    input  logic [RoB_WIDTH-1:0]         new_entry_robEntry,
    input  logic [6:0]                   new_entry_opcode,
    input  logic [31:0]                  new_entry_Vj,
    input  logic [31:0]                  new_entry_Vk,
    input  logic [RoB_WIDTH:0]           new_entry_Qj,
    input  logic [RoB_WIDTH:0]           new_entry_Qk,
    input  logic [31:0]                  new_entry_imm,
    input  logic [31:0]                  new_entry_pc,
    input  logic [CDB_NUM-1:0]           CDB_en,
    input  logic [CDB_NUM*RoB_WIDTH-1:0] CDB_index,
    input  logic [CDB_NUM*32-1:0]        CDB_data,
    output logic                         RS_update_en,
    output logic [RoB_WIDTH-1:0]         RS_update_index,
    output logic [31:0]                  RS_update_data,
    input  logic                         RS_update_ready,
    input  logic                         flush_signal,
    output logic                         isEmpty,
    output logic                         isFull,
    output logic [RS_WIDTH:0]            count
);
    localparam logic [RoB_WIDTH:0] ND = (RoB_WIDTH+1)'(NON_DEP);

    logic [RS_SIZE-1:0]   busy_q;
    logic [RoB_WIDTH-1:0] rob_q [RS_SIZE];
    logic [6:0]           op_q  [RS_SIZE];
    logic [31:0]          vj_q  [RS_SIZE];
    logic [31:0]          vk_q  [RS_SIZE];
    logic [RoB_WIDTH:0]   qj_q  [RS_SIZE];
    logic [RoB_WIDTH:0]   qk_q  [RS_SIZE];
    logic [31:0]          imm_q [RS_SIZE];
    logic [31:0]          pc_q  [RS_SIZE];
    // age_q[a][b] set means entry a was dispatched before entry b
    logic [RS_SIZE-1:0]   age_q [RS_SIZE];

    logic                 upd_en_q;
    logic [RoB_WIDTH-1:0] upd_idx_q;
    logic [31:0]          upd_dat_q;

    logic [32:0]          sj [RS_SIZE];
    logic [32:0]          sk [RS_SIZE];
    logic [32:0]          new_sj;
    logic [32:0]          new_sk;
    logic [RS_SIZE-1:0]   ready;
    logic [RS_WIDTH-1:0]  free_idx;
    logic [RS_WIDTH-1:0]  sel_idx;
    logic                 sel_vld;
    logic                 issue;
    logic                 dispatch;
    logic [31:0]          alu_dat;

    // Returns {hit, data}; bus 0 wins when several buses carry the tag
    function automatic logic [32:0] snoop(input logic [RoB_WIDTH:0]           tag,
                                          input logic [CDB_NUM-1:0]           en,
                                          input logic [CDB_NUM*RoB_WIDTH-1:0] idx,
                                          input logic [CDB_NUM*32-1:0]        dat);
        logic [32:0] r;
        r = '0;
        for (int k = CDB_NUM - 1; k >= 0; k--) begin
            if (en[k] && (tag == {1'b0, idx[k*RoB_WIDTH +: RoB_WIDTH]})) begin
                r = {1'b1, dat[k*32 +: 32]};
            end
        end
        return r;
    endfunction

    // Operand snooping, ready vector, lowest idle slot and oldest ready entry
    always_comb begin
        logic older;
        older    = 1'b0;
        new_sj   = snoop(new_entry_Qj, CDB_en, CDB_index, CDB_data);
        new_sk   = snoop(new_entry_Qk, CDB_en, CDB_index, CDB_data);
        free_idx = '0;
        sel_idx  = '0;
        sel_vld  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            sj[i]    = snoop(qj_q[i], CDB_en, CDB_index, CDB_data);
            sk[i]    = snoop(qk_q[i], CDB_en, CDB_index, CDB_data);
            ready[i] = busy_q[i] && (qj_q[i] == ND) && (qk_q[i] == ND);
            if (!busy_q[i]) begin
                free_idx = RS_WIDTH'(i);
            end
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            older = 1'b0;
            for (int j = 0; j < RS_SIZE; j++) begin
                if (ready[j] && age_q[j][i]) begin
                    older = 1'b1;
                end
            end
            if (ready[i] && !older) begin
                sel_vld = 1'b1;
                sel_idx = RS_WIDTH'(i);
            end
        end
    end

    // Occupancy count derived from the busy bits
    always_comb begin
        count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            count = count + {{RS_WIDTH{1'b0}}, busy_q[i]};
        end
    end

    assign isEmpty         = ~|busy_q;
    assign isFull          = &busy_q;
    assign issue           = sel_vld && (!upd_en_q || RS_update_ready);
    assign dispatch        = new_entry_en && !isFull;
    assign RS_update_en    = upd_en_q;
    assign RS_update_index = upd_idx_q;
    assign RS_update_data  = upd_dat_q;

    rs_alu u_alu (
        .opcode_i (op_q[sel_idx]),
        .vj_i     (vj_q[sel_idx]),
        .vk_i     (vk_q[sel_idx]),
        .imm_i    (imm_q[sel_idx]),
        .pc_i     (pc_q[sel_idx]),
        .data_o   (alu_dat)
    );

    // Entry state, wakeup, issue, dispatch and age tracking
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                qj_q[i]  <= ND;
                qk_q[i]  <= ND;
                age_q[i] <= '0;
            end
            busy_q    <= '0;
            upd_en_q  <= 1'b0;
            upd_idx_q <= '0;
            upd_dat_q <= '0;
        end else if (rdy_in) begin
            if (flush_signal) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    qj_q[i]  <= ND;
                    qk_q[i]  <= ND;
                    age_q[i] <= '0;
                end
                busy_q   <= '0;
                upd_en_q <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && sj[i][32]) begin
                        qj_q[i] <= ND;
                        vj_q[i] <= sj[i][31:0];
                    end
                    if (busy_q[i] && sk[i][32]) begin
                        qk_q[i] <= ND;
                        vk_q[i] <= sk[i][31:0];
                    end
                end
                if (issue) begin
                    busy_q[sel_idx] <= 1'b0;
                    upd_en_q        <= 1'b1;
                    upd_idx_q       <= rob_q[sel_idx];
                    upd_dat_q       <= alu_dat;
                end else if (RS_update_ready) begin
                    upd_en_q <= 1'b0;
                end
                if (dispatch) begin
                    busy_q[free_idx] <= 1'b1;
                    rob_q[free_idx]  <= new_entry_robEntry;
                    op_q[free_idx]   <= new_entry_opcode;
                    imm_q[free_idx]  <= new_entry_imm;
                    pc_q[free_idx]   <= new_entry_pc;
                    qj_q[free_idx]   <= new_sj[32] ? ND : new_entry_Qj;
                    vj_q[free_idx]   <= new_sj[32] ? new_sj[31:0] : new_entry_Vj;
                    qk_q[free_idx]   <= new_sk[32] ? ND : new_entry_Qk;
                    vk_q[free_idx]   <= new_sk[32] ? new_sk[31:0] : new_entry_Vk;
                    for (int j = 0; j < RS_SIZE; j++) begin
                        age_q[free_idx][j] <= 1'b0;
                        age_q[j][free_idx] <= (RS_WIDTH'(j) != free_idx);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: queue-based reference model checked every cycle plus directed literals.
// Latency: n/a.
// Backpressure: exercises held results via RS_update_ready.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    localparam int ND = 8;

    logic        clk;
    logic        rst_in, rdy_in, ne_en, upd_rdy, flush;
    logic [2:0]  ne_rob;
    logic [6:0]  ne_op;
    logic [31:0] ne_vj, ne_vk, ne_imm, ne_pc;
    logic [3:0]  ne_qj, ne_qk;
    logic        cdb_en  [2];
    logic [2:0]  cdb_tag [2];
    logic [31:0] cdb_dat [2];
    logic [1:0]  cdb_en_w;
    logic [5:0]  cdb_idx_w;
    logic [63:0] cdb_dat_w;
    logic        RS_update_en, isEmpty, isFull;
    logic [2:0]  RS_update_index;
    logic [31:0] RS_update_data;
    logic [3:0]  count;

    assign cdb_en_w  = {cdb_en[1], cdb_en[0]};
    assign cdb_idx_w = {cdb_tag[1], cdb_tag[0]};
    assign cdb_dat_w = {cdb_dat[1], cdb_dat[0]};

    alu_reservation_station dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .new_entry_en(ne_en), .new_entry_robEntry(ne_rob), .new_entry_opcode(ne_op),
        .new_entry_Vj(ne_vj), .new_entry_Vk(ne_vk), .new_entry_Qj(ne_qj), .new_entry_Qk(ne_qk),
        .new_entry_imm(ne_imm), .new_entry_pc(ne_pc),
        .CDB_en(cdb_en_w), .CDB_index(cdb_idx_w), .CDB_data(cdb_dat_w),
        .RS_update_en(RS_update_en), .RS_update_index(RS_update_index), .RS_update_data(RS_update_data),
        .RS_update_ready(upd_rdy), .flush_signal(flush),
        .isEmpty(isEmpty), .isFull(isFull), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: age-ordered list of pending ops ----------------
    typedef struct {
        int          rob;
        logic [6:0]  op;
        logic [31:0] vj, vk, imm, pc;
        int          qj, qk;
    } ent_t;

    ent_t        mq[$];
    logic        m_en;
    logic [2:0]  m_idx;
    logic [31:0] m_dat;
    bit          m_init = 0;

    function automatic logic [31:0] model_alu(input ent_t e);
        logic [31:0] a, b, im, tk, nt;
        a = e.vj; b = e.vk; im = e.imm; tk = e.pc + e.imm; nt = e.pc + 32'd4;
        case (e.op)
            OP_JALR:  return (a + im) & 32'hFFFF_FFFE;
            OP_BEQ:   return (a == b) ? tk : nt;
            OP_BNE:   return (a != b) ? tk : nt;
            OP_BLT:   return ($signed(a) <  $signed(b)) ? tk : nt;
            OP_BGE:   return ($signed(a) >= $signed(b)) ? tk : nt;
            OP_BLTU:  return (a <  b) ? tk : nt;
            OP_BGEU:  return (a >= b) ? tk : nt;
            OP_ADDI:  return a + im;
            OP_SLTI:  return ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
            OP_SLTIU: return (a < im) ? 32'd1 : 32'd0;
            OP_XORI:  return a ^ im;
            OP_ORI:   return a | im;
            OP_ANDI:  return a & im;
            OP_SLLI:  return a << im[4:0];
            OP_SRLI:  return a >> im[4:0];
            OP_SRAI:  return 32'($signed(a) >>> im[4:0]);
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_SLL:   return a << b[4:0];
            OP_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            OP_XORR:  return a ^ b;
            OP_SRL:   return a >> b[4:0];
            OP_SRA:   return 32'($signed(a) >>> b[4:0]);
            OP_ORR:   return a | b;
            OP_ANDR:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic bit cdb_lookup(input int tag, output logic [31:0] d);
        d = 32'd0;
        for (int k = 0; k < 2; k++) begin
            if (cdb_en[k] && tag == int'(cdb_tag[k])) begin
                d = cdb_dat[k];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        bit          full;
        int          pick;
        ent_t        e;
        logic [31:0] d;
        full = (mq.size() == 8);
        pick = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].qj == ND && mq[i].qk == ND) begin
                pick = i;
                break;
            end
        end
        if (pick >= 0 && (!m_en || upd_rdy)) begin
            m_en  = 1'b1;
            m_idx = 3'(mq[pick].rob);
            m_dat = model_alu(mq[pick]);
            mq.delete(pick);
        end else if (upd_rdy) begin
            m_en = 1'b0;
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (cdb_lookup(e.qj, d)) begin e.qj = ND; e.vj = d; end
            if (cdb_lookup(e.qk, d)) begin e.qk = ND; e.vk = d; end
            mq[i] = e;
        end
        if (ne_en && !full) begin
            e.rob = int'(ne_rob); e.op = ne_op; e.imm = ne_imm; e.pc = ne_pc;
            e.qj = int'(ne_qj); e.vj = ne_vj; e.qk = int'(ne_qk); e.vk = ne_vk;
            if (cdb_lookup(e.qj, d)) begin e.qj = ND; e.vj = d; end
            if (cdb_lookup(e.qk, d)) begin e.qk = ND; e.vk = d; end
            mq.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        if (rst_in === 1'b0) begin
            mq.delete();
            m_en = 1'b0; m_idx = 3'd0; m_dat = 32'd0;
            m_init = 1'b1;
        end else if (rdy_in) begin
            if (flush) begin
                mq.delete();
                m_en = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_init) begin
            check("cyc_upd_en",    32'(RS_update_en),    32'(m_en));
            check("cyc_upd_index", 32'(RS_update_index), 32'(m_idx));
            check("cyc_upd_data",  RS_update_data,       m_dat);
            check("cyc_count",     32'(count),           32'(mq.size()));
            check("cyc_empty",     32'(isEmpty),         32'(mq.size() == 0));
            check("cyc_full",      32'(isFull),          32'(mq.size() == 8));
        end
    end

    // Collect every accepted result in order
    typedef struct { int idx; logic [31:0] dat; } acc_t;
    acc_t acc_q[$];

    always @(posedge clk) begin
        if (rst_in === 1'b1 && rdy_in === 1'b1 && flush === 1'b0 &&
            RS_update_en === 1'b1 && upd_rdy === 1'b1) begin
            acc_q.push_back('{int'(RS_update_index), RS_update_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic dispatch(input int rob, input logic [6:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [31:0] imm, input logic [31:0] pc, input int qj, input int qk);
        check("dispatch_while_full", 32'(isFull), 32'd0);
        ne_en = 1'b1; ne_rob = 3'(rob); ne_op = op; ne_vj = vj; ne_vk = vk;
        ne_imm = imm; ne_pc = pc; ne_qj = 4'(qj); ne_qk = 4'(qk);
        @(negedge clk);
        ne_en = 1'b0;
    endtask

    task automatic expect_issue(input string name, input int rob, input logic [31:0] dat);
        acc_t r;
        int   waited;
        waited = 0;
        while (acc_q.size() == 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (acc_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no result accepted within 20 cycles, expected rob %0d", name, rob);
        end else begin
            r = acc_q.pop_front();
            check({name, "_idx"},  32'(r.idx), 32'(rob));
            check({name, "_data"}, r.dat,      dat);
        end
    endtask

    task automatic cdb_pulse(input int bus, input int tag, input logic [31:0] dat);
        cdb_en[bus] = 1'b1; cdb_tag[bus] = 3'(tag); cdb_dat[bus] = dat;
        @(negedge clk);
        cdb_en[bus] = 1'b0;
    endtask

    // Directed ALU vectors: rob, opcode, Vj, Vk, imm, pc, expected result
    int          t_rob [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    logic [6:0]  t_op  [8] = '{OP_JALR, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_BGE, 7'h7F, OP_BGEU};
    logic [31:0] t_vj  [8] = '{32'h1001, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF};
    logic [31:0] t_vk  [8] = '{32'd0, 32'd7, 32'h21, 32'd1, 32'd1, 32'd1, 32'd9, 32'd1};
    logic [31:0] t_imm [8] = '{32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'h20, 32'd3, 32'h20};
    logic [31:0] t_pc  [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h200, 32'd0, 32'h200};
    logic [31:0] t_exp [8] = '{32'h1004, 32'hFFFF_FFFE, 32'd2, 32'd1, 32'd0, 32'h204, 32'd0, 32'h220};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; ne_en = 1'b0; upd_rdy = 1'b1; flush = 1'b0;
        ne_rob = '0; ne_op = '0; ne_vj = '0; ne_vk = '0; ne_imm = '0; ne_pc = '0;
        ne_qj = 4'd8; ne_qk = 4'd8;
        for (int k = 0; k < 2; k++) begin
            cdb_en[k] = 1'b0; cdb_tag[k] = '0; cdb_dat[k] = '0;
        end

        // Reset for one cycle
        @(negedge clk);
        rst_in = 1'b1;
        check("reset_empty", 32'(isEmpty), 32'd1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_upd_en", 32'(RS_update_en), 32'd0);
        check("reset_full", 32'(isFull), 32'd0);

        // addi ready at dispatch: result visible one cycle later
        dispatch(2, OP_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, ND, ND);
        @(negedge clk);
        check("lat_upd_en", 32'(RS_update_en), 32'd1);
        check("lat_index", 32'(RS_update_index), 32'd2);
        check("lat_data", RS_update_data, 32'd2);
        expect_issue("addi", 2, 32'd2);

        // Wakeup from bus 1
        dispatch(1, OP_ADD, 32'd0, 32'd7, 32'd0, 32'd0, 4, ND);
        cdb_pulse(1, 4, 32'h10);
        expect_issue("wake_bus1", 1, 32'h17);

        // Signed/unsigned branches and arithmetic shift-right with shift amount masking
        dispatch(0, OP_BLT,  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, ND, ND);
        dispatch(1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, ND, ND);
        dispatch(2, OP_SRAI, 32'h8000_0000, 32'd0, 32'h21, 32'd0, ND, ND);
        expect_issue("blt", 0, 32'h120);
        expect_issue("bltu", 1, 32'h104);
        expect_issue("srai", 2, 32'hC000_0000);

        // Further ALU vectors, back to back
        for (int i = 0; i < 8; i++) dispatch(t_rob[i], t_op[i], t_vj[i], t_vk[i], t_imm[i], t_pc[i], ND, ND);
        for (int i = 0; i < 8; i++) expect_issue("alu_vec", t_rob[i], t_exp[i]);

        // Age order: rob4 lands in a lower slot than rob3 but is younger
        dispatch(6, OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, ND, ND);
        dispatch(3, OP_ADDI, 32'd0, 32'd0, 32'h30, 32'd0, 5, ND);
        dispatch(4, OP_ADDI, 32'd0, 32'd0, 32'h40, 32'd0, 5, ND);
        cdb_pulse(0, 5, 32'h100);
        expect_issue("age_first", 6, 32'd3);
        expect_issue("age_second", 3, 32'h130);
        expect_issue("age_third", 4, 32'h140);

        // Backpressure: one result held, two entries waiting
        upd_rdy = 1'b0;
        dispatch(1, OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, ND, ND);
        dispatch(2, OP_ADD, 32'd2, 32'd2, 32'd0, 32'd0, ND, ND);
        dispatch(3, OP_ADD, 32'd3, 32'd3, 32'd0, 32'd0, ND, ND);
        repeat (3) begin
            check("hold_count", 32'(count), 32'd2);
            check("hold_en", 32'(RS_update_en), 32'd1);
            check("hold_index", 32'(RS_update_index), 32'd1);
            check("hold_data", RS_update_data, 32'd2);
            @(negedge clk);
        end
        upd_rdy = 1'b1;
        expect_issue("bp_first", 1, 32'd2);
        expect_issue("bp_second", 2, 32'd4);
        expect_issue("bp_third", 3, 32'd6);

        // rdy_in low freezes state: a broadcast during the freeze is not captured
        dispatch(5, OP_ADDI, 32'd0, 32'd0, 32'd1, 32'd0, 6, ND);
        rdy_in = 1'b0;
        cdb_pulse(0, 6, 32'h20);
        rdy_in = 1'b1;
        repeat (2) @(negedge clk);
        check("freeze_no_issue", 32'(acc_q.size()), 32'd0);
        check("freeze_count", 32'(count), 32'd1);
        cdb_pulse(0, 6, 32'h20);
        expect_issue("after_freeze", 5, 32'h21);

        // Fill, then flush
        for (int i = 0; i < 8; i++) dispatch(i, OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 7, ND);
        check("fill_full", 32'(isFull), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_empty", 32'(isEmpty), 32'd1);
        check("flush_upd_en", 32'(RS_update_en), 32'd0);
        check("flush_count", 32'(count), 32'd0);

        // Dispatch bypass: both operands taken from same-cycle broadcasts
        cdb_en[0] = 1'b1; cdb_tag[0] = 3'd5; cdb_dat[0] = 32'h40;
        cdb_en[1] = 1'b1; cdb_tag[1] = 3'd2; cdb_dat[1] = 32'h3;
        dispatch(5, OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5, 2);
        cdb_en[0] = 1'b0; cdb_en[1] = 1'b0;
        check("bypass_latency_en", 32'(RS_update_en), 32'd0);
        expect_issue("bypass", 5, 32'h43);

        repeat (3) @(negedge clk);
        check("final_empty", 32'(isEmpty), 32'd1);
        check("final_no_extra", 32'(acc_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
